// File: rtl/vector_packer_pkg.sv
// vector_packer_pkg: shared state type, pad bit and width helpers for vector_packer.
// VECTOR_PACKER_PAD_ONES_EN selects a pad value of one instead of zero.
package vector_packer_pkg;

    typedef enum logic {FILL, FLUSH} state_t;

`ifdef VECTOR_PACKER_PAD_ONES_EN
    localparam logic PAD = 1'b1;
`else
    localparam logic PAD = 1'b0;
`endif

    function automatic int acc_w(input int in_w, input int out_w);
        return in_w + out_w - 1;
    endfunction

    function automatic int cnt_w(input int in_w, input int out_w);
        return $clog2(acc_w(in_w, out_w) + 1);
    endfunction

endpackage

// File: rtl/vector_packer.sv
// vector_packer: packs IN_W-bit fields MSB-first into OUT_W-bit words, padding the frame tail.
// VECTOR_PACKER_PAD_ONES_EN (via vector_packer_pkg) makes the pad and reset fill all ones.
module vector_packer
    import vector_packer_pkg::*;
#(
    parameter int IN_W  = 5,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             areset,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready
);

    localparam int ACC_W = acc_w(IN_W, OUT_W);
    localparam int CNT_W = cnt_w(IN_W, OUT_W);
    localparam logic [CNT_W-1:0] OW = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] IW = CNT_W'(IN_W);
    localparam logic [ACC_W-1:0] ALL_PAD = {ACC_W{PAD}};
    // pad bits that refill the LSBs vacated by a word shift
    localparam logic [ACC_W-1:0] LOW_PAD = ALL_PAD & ~({ACC_W{1'b1}} << OUT_W);

    state_t            state, state_n;
    logic [ACC_W-1:0]  acc, acc_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              in_fire, out_fire;

    always_comb begin
        in_ready  = (state == FILL) && (cnt < OW);
        out_valid = (cnt >= OW) || (state == FLUSH && cnt != '0);
        out_last  = (state == FLUSH) && (cnt <= OW) && (cnt != '0);
        out_data  = acc[ACC_W-1 -: OUT_W];
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        acc_n     = acc;
        cnt_n     = cnt;
        state_n   = state;
        if (in_fire) begin
            acc_n[ACC_W-1-int'(cnt) -: IN_W] = in_data;
            cnt_n   = cnt + IW;
            state_n = in_last ? FLUSH : state;
        end else if (out_fire) begin
            acc_n   = (acc << OUT_W) | LOW_PAD;
            cnt_n   = (cnt > OW) ? cnt - OW : '0;
            state_n = out_last ? FILL : state;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= FILL;
            acc   <= ALL_PAD;
            cnt   <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
        end
    end

endmodule
